// File: rtl/add_n.sv
// N-bit ripple-carry adder with carry-in and carry-out, plus a one-cycle registered
// copy of the result and a signed-overflow flag for pipelined users.
module add_n #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic [N-1:0] s_q,
  output logic         c_out_q,
  output logic         ovf_q
);

  logic        [N:0]   carry;
  logic signed [N-1:0] x_s;
  logic signed [N-1:0] y_s;
  logic signed [N-1:0] s_s;

  logic [N-1:0] s_p1;
  logic         c_out_p1;
  logic         ovf_p1;

  // Overflow in two's complement: like-signed operands whose sum changes sign.
  function automatic logic signed_ovf(input logic signed [N-1:0] a,
                                      input logic signed [N-1:0] b,
                                      input logic signed [N-1:0] sum);
    return (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
  endfunction

  // Stage p0: combinational ripple chain, valid regardless of clock or reset.
  assign carry[0] = c_in;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_fa
      assign s[i]       = x[i] ^ y[i] ^ carry[i];
      assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
    end
  endgenerate

  assign c_out = carry[N];

  assign x_s = x;
  assign y_s = y;
  assign s_s = s;

  // Stage p1: registered result, cleared asynchronously by reset_.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      s_p1     <= '0;
      c_out_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      s_p1     <= s;
      c_out_p1 <= c_out;
      ovf_p1   <= signed_ovf(x_s, y_s, s_s);
    end
  end

  assign s_q     = s_p1;
  assign c_out_q = c_out_p1;
  assign ovf_q   = ovf_p1;

endmodule

// File: tb/tb_add_n.sv
// Scoreboard bench for add_n at N=10 and N=8 running side by side.
module tb_add_n;

  logic       clock;
  logic       reset_;
  logic [9:0] x10, y10, s10, s_q10;
  logic       c_in10, c_out10, c_out_q10, ovf_q10;
  logic [7:0] x8, y8, s8, s_q8;
  logic       c_in8, c_out8, c_out_q8, ovf_q8;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        ovf;
  } exp_t;

  exp_t q10[$];
  exp_t q8[$];

  add_n #(.N(10)) dut10 (
    .clock(clock), .reset_(reset_), .x(x10), .y(y10), .c_in(c_in10),
    .s(s10), .c_out(c_out10), .s_q(s_q10), .c_out_q(c_out_q10), .ovf_q(ovf_q10)
  );

  add_n #(.N(8)) dut8 (
    .clock(clock), .reset_(reset_), .x(x8), .y(y8), .c_in(c_in8),
    .s(s8), .c_out(c_out8), .s_q(s_q8), .c_out_q(c_out_q8), .ovf_q(ovf_q8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n, input logic [63:0] a, input logic [63:0] b,
                                 input logic c);
    exp_t        r;
    logic [64:0] full;
    logic [63:0] mask;
    mask  = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    full  = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
    r.s   = full[63:0] & mask;
    r.c   = full[n];
    r.ovf = (a[n-1] == b[n-1]) && (r.s[n-1] != a[n-1]);
    return r;
  endfunction

  task automatic push_current();
    q10.push_back(model(10, {54'd0, x10}, {54'd0, y10}, c_in10));
    q8.push_back(model(8, {56'd0, x8}, {56'd0, y8}, c_in8));
  endtask

  // Drive both DUTs on the falling edge, check the combinational path, queue the registered expectation.
  task automatic drive(input logic [9:0] a10, input logic [9:0] b10, input logic c10,
                       input logic [7:0] a8, input logic [7:0] b8, input logic c8);
    exp_t e;
    @(negedge clock);
    x10 = a10; y10 = b10; c_in10 = c10;
    x8  = a8;  y8  = b8;  c_in8  = c8;
    #1;
    e = model(10, {54'd0, a10}, {54'd0, b10}, c10);
    check("s10", {54'd0, s10}, e.s);
    check("c_out10", {63'd0, c_out10}, {63'd0, e.c});
    e = model(8, {56'd0, a8}, {56'd0, b8}, c8);
    check("s8", {56'd0, s8}, e.s);
    check("c_out8", {63'd0, c_out8}, {63'd0, e.c});
    push_current();
  endtask

  task automatic sample();
    exp_t e;
    @(posedge clock);
    #1;
    if (q10.size() == 0 || q8.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = q10.pop_front();
      check("s_q10", {54'd0, s_q10}, e.s);
      check("c_out_q10", {63'd0, c_out_q10}, {63'd0, e.c});
      check("ovf_q10", {63'd0, ovf_q10}, {63'd0, e.ovf});
      e = q8.pop_front();
      check("s_q8", {56'd0, s_q8}, e.s);
      check("c_out_q8", {63'd0, c_out_q8}, {63'd0, e.c});
      check("ovf_q8", {63'd0, ovf_q8}, {63'd0, e.ovf});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_ = 1'b0;
    x10 = '0; y10 = '0; c_in10 = 1'b0;
    x8  = '0; y8  = '0; c_in8  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_s_q10", {54'd0, s_q10}, 64'd0);
    check("rst_c_out_q10", {63'd0, c_out_q10}, 64'd0);
    check("rst_ovf_q10", {63'd0, ovf_q10}, 64'd0);
    check("rst_s_q8", {56'd0, s_q8}, 64'd0);
    check("rst_c_out_q8", {63'd0, c_out_q8}, 64'd0);
    check("rst_ovf_q8", {63'd0, ovf_q8}, 64'd0);
    @(negedge clock);
    reset_ = 1'b1;

    // 5*255 through the times-5 operand layout.
    drive(10'h0FF, 10'h3FC, 1'b0, 8'hFF, 8'hFF, 1'b1);
    check("x5_255_s", {54'd0, s10}, 64'h0FB);
    check("x5_255_c", {63'd0, c_out10}, 64'd1);
    sample();
    check("x5_255_s_q", {54'd0, s_q10}, 64'h0FB);
    check("x5_255_ovf", {63'd0, ovf_q10}, 64'd0);

    // 5*3: combinational result appears while the register holds the previous sum.
    drive(10'h003, 10'h00C, 1'b0, 8'h7F, 8'h01, 1'b0);
    check("x5_3_s", {54'd0, s10}, 64'h00F);
    check("x5_3_hold", {54'd0, s_q10}, 64'h0FB);
    sample();

    drive(10'h3FF, 10'h000, 1'b1, 8'hFF, 8'h00, 1'b1);
    check("wrap_s", {54'd0, s10}, 64'h000);
    check("wrap_c", {63'd0, c_out10}, 64'd1);
    sample();
    check("wrap_ovf", {63'd0, ovf_q10}, 64'd0);

    drive(10'h1FF, 10'h001, 1'b0, 8'h80, 8'h80, 1'b0);
    sample();
    check("ovf_only_s_q", {54'd0, s_q10}, 64'h200);
    check("ovf_only_c", {63'd0, c_out_q10}, 64'd0);
    check("ovf_only_ovf", {63'd0, ovf_q10}, 64'd1);
    check("ovf_and_carry8", {62'd0, c_out_q8, ovf_q8}, 64'd3);

    // Asynchronous reset in mid-cycle.
    drive(10'h3FF, 10'h3FF, 1'b1, 8'hFF, 8'hFF, 1'b1);
    sample();
    check("max_s_q", {54'd0, s_q10}, 64'h3FF);
    check("max_c_q", {63'd0, c_out_q10}, 64'd1);
    #2;
    reset_ = 1'b0;
    #1;
    check("async_s_q", {54'd0, s_q10}, 64'd0);
    check("async_c_q", {63'd0, c_out_q10}, 64'd0);
    check("async_ovf", {63'd0, ovf_q10}, 64'd0);
    check("async_s_q8", {56'd0, s_q8}, 64'd0);
    check("async_comb_s", {54'd0, s10}, 64'h3FF);
    check("async_comb_c", {63'd0, c_out10}, 64'd1);
    @(posedge clock);
    #1;
    check("held_s_q", {54'd0, s_q10}, 64'd0);
    @(negedge clock);
    reset_ = 1'b1;
    push_current();
    sample();
    check("release_s_q", {54'd0, s_q10}, 64'h3FF);

    for (int k = 0; k < 1000; k++) begin
      drive(10'($urandom), 10'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom));
      sample();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
